// File: rtl/multicycle_adder.sv
// Multicycle ripple adder/subtractor: adds CHUNK bits per clock over N = WIDTH/CHUNK
// cycles, presenting the registered result with a one-cycle done pulse.
module multicycle_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : gen_param_check
        $error("multicycle_adder: CHUNK must be >= 1 and divide WIDTH");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc;
    logic             sub_r;
    logic             carry;
    logic [IW-1:0]    idx;

    logic [CHUNK:0]   csum;
    logic             cmsb;
    logic [WIDTH-1:0] acc_next;
    logic             last;

    // Operands shift right one chunk per cycle, so the active chunk is always
    // at bit 0; finished chunks enter the accumulator from the top.
    always_comb begin
        csum     = {1'b0, a_r[CHUNK-1:0]} + {1'b0, b_r[CHUNK-1:0]} + (CHUNK+1)'(carry);
        cmsb     = a_r[CHUNK-1] ^ b_r[CHUNK-1] ^ csum[CHUNK-1];
        acc_next = (acc >> CHUNK) | (WIDTH'(csum[CHUNK-1:0]) << (WIDTH - CHUNK));
        last     = (idx == IW'(N - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            carry <= 1'b0;
            idx   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r   <= a;
                        b_r   <= sub ? ~b : b;
                        sub_r <= sub;
                        carry <= cin ^ sub;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_r   <= a_r >> CHUNK;
                    b_r   <= b_r >> CHUNK;
                    acc   <= acc_next;
                    carry <= csum[CHUNK];
                    idx   <= idx + IW'(1);
                    if (last) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        s     <= acc_next;
                        cout  <= csum[CHUNK] ^ sub_r;
                        ovf   <= cmsb ^ csum[CHUNK];
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_adder.sv
// Bench for multicycle_adder: five instances (CHUNK = 1,2,4,8,16) share stimulus and are
// checked every cycle against an arithmetic reference, plus literal directed cases.
module tb_multicycle_adder;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;

    logic [4:0]       busy_v;
    logic [4:0]       done_v;
    logic [4:0]       cout_v;
    logic [4:0]       ovf_v;
    logic [4:0][15:0] s_v;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 5; g++) begin : gen_dut
        multicycle_adder #(.WIDTH(16), .CHUNK(1 << g)) u_dut (
            .clk  (clk),
            .rst  (rst),
            .start(start),
            .a    (a),
            .b    (b),
            .cin  (cin),
            .sub  (sub),
            .busy (busy_v[g]),
            .done (done_v[g]),
            .s    (s_v[g]),
            .cout (cout_v[g]),
            .ovf  (ovf_v[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference result {cout, ovf, s} from plain integer arithmetic.
    function automatic logic [17:0] ref_op(input logic [15:0] x, input logic [15:0] y,
                                           input logic ci, input logic sb);
        int ux, uy, sx, sy, c, r, sr;
        logic co, ov;
        logic [15:0] rs;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        c  = ci ? 1 : 0;
        if (!sb) begin
            r  = ux + uy + c;
            sr = sx + sy + c;
            co = (r > 65535);
        end else begin
            r  = ux - uy - c;
            sr = sx - sy - c;
            co = (r < 0);
        end
        rs = 16'(r & 32'hFFFF);
        ov = (sr > 32767) || (sr < -32768);
        return {co, ov, rs};
    endfunction

    // Transaction-level model: an accepted op keeps the unit busy for 16>>g cycles,
    // then the result appears together with a single done cycle.
    logic [4:0]  m_busy;
    logic [4:0]  m_done;
    logic [17:0] m_res [5];
    logic [17:0] pend  [5];
    int          rem   [5];

    always @(posedge clk) begin
        for (int g = 0; g < 5; g++) begin
            if (rst) begin
                m_busy[g] <= 1'b0;
                m_done[g] <= 1'b0;
                m_res[g]  <= '0;
                rem[g]    <= 0;
            end else if (rem[g] > 1) begin
                rem[g] <= rem[g] - 1;
            end else if (rem[g] == 1) begin
                rem[g]    <= 0;
                m_busy[g] <= 1'b0;
                m_done[g] <= 1'b1;
                m_res[g]  <= pend[g];
            end else if (start) begin
                pend[g]   <= ref_op(a, b, cin, sub);
                rem[g]    <= 16 >> g;
                m_busy[g] <= 1'b1;
                m_done[g] <= 1'b0;
            end else begin
                m_busy[g] <= 1'b0;
                m_done[g] <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            for (int g = 0; g < 5; g++) begin
                chk($sformatf("chunk%0d_outputs", 1 << g),
                    32'({busy_v[g], done_v[g], cout_v[g], ovf_v[g], s_v[g]}),
                    32'({m_busy[g], m_done[g], m_res[g]}));
            end
        end
    end

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        ci;
        logic        sb;
        logic [15:0] es;
        logic        ec;
        logic        eo;
    } vec_t;

    vec_t vecs [7];

    task automatic run_op(input vec_t v, input int id);
        int nbusy;
        bit seen;
        chk($sformatf("model_v%0d", id), 32'(ref_op(v.x, v.y, v.ci, v.sb)), 32'({v.ec, v.eo, v.es}));
        @(posedge clk); #1;
        a = v.x; b = v.y; cin = v.ci; sub = v.sb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nbusy = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done_v[2]) seen = 1'b1;
            else if (busy_v[2]) nbusy++;
        end
        chk($sformatf("done_seen_v%0d", id), 32'(seen), 32'd1);
        chk($sformatf("busy_len_v%0d", id), 32'(nbusy), 32'd4);
        chk($sformatf("result_v%0d", id), 32'({cout_v[2], ovf_v[2], s_v[2]}), 32'({v.ec, v.eo, v.es}));
    endtask

    task automatic wait_done2(output bit seen, output int at);
        seen = 1'b0;
        at = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done_v[2]) begin
                seen = 1'b1;
                at = cyc;
            end
        end
    endtask

    initial begin
        bit seen1, seen2;
        int t1, t2, ndone;

        vecs[0] = '{16'h0007, 16'h0008, 1'b0, 1'b0, 16'h000F, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[4] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0};
        vecs[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1};
        vecs[6] = '{16'h0009, 16'h0004, 1'b1, 1'b1, 16'h0004, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b1; a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0;
        @(posedge clk); #1;
        checking = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("reset_state", 32'({busy_v[2], done_v[2], cout_v[2], ovf_v[2], s_v[2]}), 32'd0);

        for (int i = 0; i < 7; i++) run_op(vecs[i], i);

        // Start held high; operands change mid-run and are picked up only in the DONE cycle.
        @(posedge clk); #1;
        a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; start = 1'b1;
        repeat (2) @(posedge clk);
        #1 a = 16'h0100; b = 16'h0001;
        wait_done2(seen1, t1);
        chk("hs_first_done", 32'(seen1), 32'd1);
        chk("hs_first_result", 32'({cout_v[2], ovf_v[2], s_v[2]}), 32'({2'b00, 16'h2345}));
        wait_done2(seen2, t2);
        chk("hs_second_done", 32'(seen2), 32'd1);
        chk("hs_second_result", 32'({cout_v[2], ovf_v[2], s_v[2]}), 32'({2'b00, 16'h0101}));
        chk("hs_done_period", 32'(t2 - t1), 32'd5);
        @(posedge clk); #1 start = 1'b0;
        repeat (20) @(posedge clk);

        // Reset on the second busy cycle aborts the operation.
        #1 a = 16'h00F0; b = 16'h000F; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_state", 32'({busy_v[2], done_v[2], s_v[2]}), 32'd0);
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (done_v[2]) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        run_op(vecs[0], 7);
        repeat (20) @(posedge clk);

        for (int i = 0; i < 800; i++) begin
            @(posedge clk); #1;
            rst   = ($urandom_range(0, 63) == 0);
            start = ($urandom_range(0, 1) == 1);
            a     = 16'($urandom);
            b     = 16'($urandom);
            cin   = 1'($urandom);
            sub   = 1'($urandom);
        end
        #1 rst = 1'b0; start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/multicycle_adder.md
MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the operand and result width in bits.
REQ-002 Parameter CHUNK, default 4, SHALL set the bits added per clock; legal only if CHUNK>=1 and WIDTH%CHUNK==0. N = WIDTH/CHUNK.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with these ports:
- clk  input  1  rising-edge clock, the single clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request to begin an operation.
- a  input  WIDTH  operand A, unsigned/two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for add; borrow-in for subtract.
- sub  input  1  0 = add, 1 = subtract.
- busy  output  1  operation in progress.
- done  output  1  one-cycle result-valid pulse.
- s  output  WIDTH  registered result.
- cout  output  1  carry-out for add; borrow-out for subtract.
- ovf  output  1  signed (two's complement) overflow.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-005 In IDLE or DONE, start=1 at a rising edge SHALL latch a, b, cin and sub, clear the chunk index, and enter RUN.
REQ-006 start SHALL be ignored while in RUN, and a, b, cin and sub SHALL NOT be resampled during RUN.
REQ-007 The RUN state SHALL last exactly N cycles, and each edge in RUN SHALL process chunk k (bits k*CHUNK+CHUNK-1 .. k*CHUNK), for k = 0..N-1, LSB chunk first.
REQ-008 The carry into chunk 0 SHALL be cin when sub=0, and ~cin when sub=1.
REQ-009 The carry into chunk k>0 SHALL be the registered carry-out of chunk k-1.
REQ-010 When sub=1, operand B SHALL be used bitwise inverted, so that s = a - b - cin mod 2^WIDTH; when sub=0, s = a + b + cin mod 2^WIDTH.
REQ-011 After the edge that processes chunk N-1, the FSM SHALL enter DONE; DONE SHALL last one cycle and then return to IDLE, unless start=1 in DONE, which goes to RUN.
REQ-012 busy SHALL be 1 exactly during RUN cycles, and done SHALL be 1 exactly during the DONE cycle.
REQ-013 Latency: with start sampled at edge T, busy SHALL be high in the N cycles following T, and done SHALL be high in the following cycle.
REQ-014 s, cout and ovf SHALL update only on the edge entering DONE, and SHALL hold their values until the next DONE entry or reset; partial sums SHALL NOT be visible on s.
REQ-015 cout SHALL equal the final carry when sub=0, and the inverted final carry (borrow) when sub=1.
REQ-016 ovf SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-017 For CHUNK==WIDTH (N=1), the RUN state SHALL last one cycle and the behaviour SHALL otherwise be identical.
REQ-018 A start asserted in the DONE cycle SHALL be accepted back-to-back, with no idle cycle, and the new operation's done SHALL follow after N further RUN cycles.

Reset
REQ-019 rst=1 at a rising edge SHALL force IDLE, busy=0, done=0, s=0, cout=0, ovf=0, and SHALL clear the internal carry and chunk index; rst SHALL take priority over start.
REQ-020 A reset during RUN SHALL abort the operation: no done pulse SHALL follow, and s/cout/ovf SHALL read 0.

Verification (WIDTH=16, CHUNK=4, N=4)
REQ-021 Add: a=7, b=8, cin=0, sub=0, start 1 cycle -> busy high 4 cycles, then done=1 with s=0x000F, cout=0, ovf=0.
REQ-022 Add carry/overflow: 0xFFFF+0x0001 -> s=0x0000, cout=1, ovf=0; 0x7FFF+0x0001 -> s=0x8000, cout=0, ovf=1; 0x0000+0x0000 with cin=1 -> s=0x0001.
REQ-023 Subtract: 5-7, cin=0 -> s=0xFFFE, cout=1, ovf=0; 0x8000-0x0001 -> s=0x7FFF, cout=0, ovf=1; 9-4 with cin=1 -> s=0x0004, cout=0.
REQ-024 Handshake: start held high continuously with the operand changed mid-RUN -> the result uses the operands latched at acceptance, and the next operation starts in the DONE cycle (done period 5 cycles).
REQ-025 Reset mid-operation: rst=1 on the 2nd busy cycle -> the next cycle shows busy=0, done=0 and s=0, with no done pulse afterwards; a fresh start then completes normally.
REQ-026 Parameter sweep: CHUNK in {1, 2, 4, 8, 16} with random operands and both modes -> results match a + b + cin / a - b - cin reference arithmetic, and busy lasts WIDTH/CHUNK cycles.
